// File: rtl/prog_delay_line_if.sv
// Sample stream bundle for prog_delay_line: input strobe/data/delay and registered delayed output.
interface prog_delay_line_if #(
  parameter int unsigned BITSIZE   = 8,
  parameter int unsigned CHANNELS  = 1,
  parameter int unsigned MAX_DEPTH = 16
);
  localparam int unsigned DW = $clog2(MAX_DEPTH + 1);
  localparam int unsigned XW = CHANNELS * BITSIZE;

  logic          in_valid;
  logic [XW-1:0] in_data;
  logic [DW-1:0] delay_sel;
  logic          out_valid;
  logic [XW-1:0] out_data;
  logic          out_primed;

  modport master (
    output in_valid, in_data, delay_sel,
    input  out_valid, out_data, out_primed
  );

  modport slave (
    input  in_valid, in_data, delay_sel,
    output out_valid, out_data, out_primed
  );
endinterface

// File: rtl/prog_delay_line.sv
// Runtime-programmable multi-lane sample delay on a circular buffer, delay counted in accepted samples.
// Optional PROG_DELAY_FLUSH_EN adds a flush input that clears the fill history.
module prog_delay_line #(
  parameter int unsigned BITSIZE   = 8,
  parameter int unsigned CHANNELS  = 1,
  parameter int unsigned MAX_DEPTH = 16,
  parameter int unsigned DW        = $clog2(MAX_DEPTH + 1)
) (
  input logic clk,
  input logic reset,
`ifdef PROG_DELAY_FLUSH_EN
  input logic flush,
`endif
  prog_delay_line_if.slave dl
);
  localparam int unsigned PW = $clog2(MAX_DEPTH);
  localparam int unsigned SW = DW + 1;
  localparam int unsigned XW = CHANNELS * BITSIZE;

  logic [XW-1:0] mem_q [MAX_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [DW-1:0] fill_q, fill_d;
  logic          out_valid_q;
  logic          out_primed_q, out_primed_d;
  logic [XW-1:0] out_data_q, out_data_d;

  logic          flush_c;
  logic [DW-1:0] de_c;
  logic [DW-1:0] fill_base_c;
  logic          primed_c;
  logic [SW-1:0] rd_raw_c;
  logic [PW-1:0] rd_addr_c;

`ifdef PROG_DELAY_FLUSH_EN
  assign flush_c = flush;
`else
  assign flush_c = 1'b0;
`endif

  // Effective delay clamp and read address; MAX_DEPTH bias keeps the sum non-negative.
  always_comb begin
    de_c = dl.delay_sel;
    if (dl.delay_sel == '0) begin
      de_c = DW'(1);
    end else if (dl.delay_sel > DW'(MAX_DEPTH)) begin
      de_c = DW'(MAX_DEPTH);
    end
    fill_base_c = flush_c ? '0 : fill_q;
    primed_c    = (SW'(fill_base_c) + SW'(1)) >= SW'(de_c);
    rd_raw_c    = SW'(wr_ptr_q) + SW'(MAX_DEPTH) + SW'(1) - SW'(de_c);
    rd_addr_c   = (rd_raw_c >= SW'(MAX_DEPTH)) ? PW'(rd_raw_c - SW'(MAX_DEPTH))
                                               : PW'(rd_raw_c);
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    fill_d       = fill_base_c;
    out_data_d   = out_data_q;
    out_primed_d = out_primed_q;
    if (dl.in_valid) begin
      wr_ptr_d = (wr_ptr_q == PW'(MAX_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
      if (fill_base_c != DW'(MAX_DEPTH)) begin
        fill_d = fill_base_c + DW'(1);
      end
      out_primed_d = primed_c;
      // De=1 reads the entry being written this cycle, so bypass the buffer.
      if (!primed_c) begin
        out_data_d = '0;
      end else if (de_c == DW'(1)) begin
        out_data_d = dl.in_data;
      end else begin
        out_data_d = mem_q[rd_addr_c];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      fill_q       <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_primed_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      fill_q       <= fill_d;
      out_valid_q  <= dl.in_valid;
      out_data_q   <= out_data_d;
      out_primed_q <= out_primed_d;
    end
  end

  // Buffer storage is not reset; the fill counter masks stale entries.
  always_ff @(posedge clk) begin
    if (dl.in_valid) begin
      mem_q[wr_ptr_q] <= dl.in_data;
    end
  end

  assign dl.out_valid  = out_valid_q;
  assign dl.out_data   = out_data_q;
  assign dl.out_primed = out_primed_q;
endmodule

// File: tb/tb_prog_delay_line.sv
// Directed self-checking bench for prog_delay_line: 1-lane/depth-16 and 3-lane/depth-5 instances.
module tb_prog_delay_line;
  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  prog_delay_line_if #(.BITSIZE(8), .CHANNELS(1), .MAX_DEPTH(16)) a_if ();
  prog_delay_line_if #(.BITSIZE(8), .CHANNELS(3), .MAX_DEPTH(5))  b_if ();

`ifdef PROG_DELAY_FLUSH_EN
  logic flush = 1'b0;
`endif

  prog_delay_line #(.BITSIZE(8), .CHANNELS(1), .MAX_DEPTH(16)) dut_a (
    .clk   (clk),
    .reset (reset),
`ifdef PROG_DELAY_FLUSH_EN
    .flush (flush),
`endif
    .dl    (a_if)
  );

  prog_delay_line #(.BITSIZE(8), .CHANNELS(3), .MAX_DEPTH(5)) dut_b (
    .clk   (clk),
    .reset (reset),
`ifdef PROG_DELAY_FLUSH_EN
    .flush (flush),
`endif
    .dl    (b_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_a(input logic v, input logic [7:0] d, input logic [4:0] s);
    a_if.in_valid  = v;
    a_if.in_data   = d;
    a_if.delay_sel = s;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    a_if.in_valid = 1'b0;
    b_if.in_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (a_if.out_valid !== 1'b0) begin errors++; $display("FAIL reset a.out_valid: got %b want 0", a_if.out_valid); end
    checks++; if (a_if.out_data !== 8'h00) begin errors++; $display("FAIL reset a.out_data: got %h want 00", a_if.out_data); end
    checks++; if (a_if.out_primed !== 1'b0) begin errors++; $display("FAIL reset a.out_primed: got %b want 0", a_if.out_primed); end
    checks++; if (b_if.out_valid !== 1'b0) begin errors++; $display("FAIL reset b.out_valid: got %b want 0", b_if.out_valid); end
    checks++; if (b_if.out_data !== 24'h0) begin errors++; $display("FAIL reset b.out_data: got %h want 0", b_if.out_data); end
    checks++; if (b_if.out_primed !== 1'b0) begin errors++; $display("FAIL reset b.out_primed: got %b want 0", b_if.out_primed); end
  endtask

  task automatic test_const_delay4();
    logic [7:0] ed [8] = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
    logic       ep [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive_a(1'b1, 8'(i + 1), 5'd4);
      checks++; if (a_if.out_valid !== 1'b1) begin errors++; $display("FAIL const4 valid[%0d]: got %b want 1", i, a_if.out_valid); end
      checks++; if (a_if.out_data !== ed[i]) begin errors++; $display("FAIL const4 data[%0d]: got %0d want %0d", i, a_if.out_data, ed[i]); end
      checks++; if (a_if.out_primed !== ep[i]) begin errors++; $display("FAIL const4 primed[%0d]: got %b want %b", i, a_if.out_primed, ep[i]); end
    end
    drive_a(1'b0, 8'hEE, 5'd4);
    checks++; if (a_if.out_valid !== 1'b0) begin errors++; $display("FAIL const4 idle valid: got %b want 0", a_if.out_valid); end
    checks++; if (a_if.out_data !== 8'd5) begin errors++; $display("FAIL const4 idle hold: got %0d want 5", a_if.out_data); end
  endtask

  task automatic test_sel_limits();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive_a(1'b1, 8'(10 + i), 5'd0);
      checks++; if (a_if.out_data !== 8'(10 + i)) begin errors++; $display("FAIL sel0 data[%0d]: got %0d want %0d", i, a_if.out_data, 10 + i); end
      checks++; if (a_if.out_primed !== 1'b1) begin errors++; $display("FAIL sel0 primed[%0d]: got %b want 1", i, a_if.out_primed); end
    end
    do_reset();
    for (int k = 0; k < 20; k++) begin
      drive_a(1'b1, 8'(k + 1), 5'd19);
      if (k == 14) begin
        checks++; if (a_if.out_data !== 8'd0 || a_if.out_primed !== 1'b0) begin errors++; $display("FAIL sel19 k14: got %0d/%b want 0/0", a_if.out_data, a_if.out_primed); end
      end
      if (k == 15) begin
        checks++; if (a_if.out_data !== 8'd1 || a_if.out_primed !== 1'b1) begin errors++; $display("FAIL sel19 k15: got %0d/%b want 1/1", a_if.out_data, a_if.out_primed); end
      end
      if (k == 19) begin
        checks++; if (a_if.out_data !== 8'd5) begin errors++; $display("FAIL sel19 k19: got %0d want 5", a_if.out_data); end
      end
    end
  endtask

  task automatic test_gaps();
    logic       v  [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [7:0] d  [7] = '{8'hA1, 8'hEE, 8'hEE, 8'hA2, 8'hA3, 8'hEE, 8'hA4};
    logic [7:0] ed [7] = '{8'h00, 8'h00, 8'h00, 8'hA1, 8'hA2, 8'hA2, 8'hA3};
    logic       ep [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive_a(v[i], d[i], v[i] ? 5'd2 : 5'd9);
      checks++; if (a_if.out_valid !== v[i]) begin errors++; $display("FAIL gaps valid[%0d]: got %b want %b", i, a_if.out_valid, v[i]); end
      checks++; if (a_if.out_data !== ed[i]) begin errors++; $display("FAIL gaps data[%0d]: got %h want %h", i, a_if.out_data, ed[i]); end
      checks++; if (a_if.out_primed !== ep[i]) begin errors++; $display("FAIL gaps primed[%0d]: got %b want %b", i, a_if.out_primed, ep[i]); end
    end
  endtask

  task automatic test_delay_change();
    do_reset();
    for (int k = 0; k < 20; k++) begin
      drive_a(1'b1, 8'(k + 100), 5'd3);
      if (k == 2) begin
        checks++; if (a_if.out_data !== 8'd100 || a_if.out_primed !== 1'b1) begin errors++; $display("FAIL chg de3 k2: got %0d/%b want 100/1", a_if.out_data, a_if.out_primed); end
      end
    end
    checks++; if (a_if.out_data !== 8'd117) begin errors++; $display("FAIL chg de3 k19: got %0d want 117", a_if.out_data); end
    drive_a(1'b1, 8'd120, 5'd8);
    checks++; if (a_if.out_data !== 8'd113) begin errors++; $display("FAIL chg de8 k20: got %0d want 113", a_if.out_data); end
    drive_a(1'b1, 8'd121, 5'd1);
    checks++; if (a_if.out_data !== 8'd121) begin errors++; $display("FAIL chg de1 k21: got %0d want 121", a_if.out_data); end
    // Growing the delay past the fill level zero-fills, then re-exposes older history.
    do_reset();
    drive_a(1'b1, 8'd7, 5'd2);
    drive_a(1'b1, 8'd8, 5'd2);
    checks++; if (a_if.out_data !== 8'd7) begin errors++; $display("FAIL grow k1: got %0d want 7", a_if.out_data); end
    drive_a(1'b1, 8'd9, 5'd5);
    checks++; if (a_if.out_data !== 8'd0 || a_if.out_primed !== 1'b0) begin errors++; $display("FAIL grow k2: got %0d/%b want 0/0", a_if.out_data, a_if.out_primed); end
    drive_a(1'b1, 8'd10, 5'd4);
    checks++; if (a_if.out_data !== 8'd7 || a_if.out_primed !== 1'b1) begin errors++; $display("FAIL grow k3: got %0d/%b want 7/1", a_if.out_data, a_if.out_primed); end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    for (int k = 0; k < 10; k++) drive_a(1'b1, 8'(k + 1), 5'd5);
    checks++; if (a_if.out_data !== 8'd6) begin errors++; $display("FAIL mid pre-reset: got %0d want 6", a_if.out_data); end
    do_reset();
    checks++; if (a_if.out_data !== 8'd0 || a_if.out_primed !== 1'b0 || a_if.out_valid !== 1'b0) begin errors++; $display("FAIL mid reset outputs: got %0d/%b/%b want 0/0/0", a_if.out_data, a_if.out_primed, a_if.out_valid); end
    for (int k = 0; k < 5; k++) begin
      drive_a(1'b1, 8'(50 + k), 5'd5);
      checks++; if (a_if.out_data !== (k == 4 ? 8'd50 : 8'd0)) begin errors++; $display("FAIL mid post data[%0d]: got %0d want %0d", k, a_if.out_data, (k == 4 ? 50 : 0)); end
      checks++; if (a_if.out_primed !== (k == 4)) begin errors++; $display("FAIL mid post primed[%0d]: got %b want %b", k, a_if.out_primed, (k == 4)); end
    end
  endtask

  task automatic test_multilane();
    logic [23:0] d;
    logic [23:0] e;
    do_reset();
    for (int k = 0; k < 12; k++) begin
      for (int c = 0; c < 3; c++) begin
        d[c*8 +: 8] = 8'((c << 6) | (k + 1));
        e[c*8 +: 8] = (k >= 4) ? 8'((c << 6) | (k - 3)) : 8'h00;
      end
      b_if.in_valid  = 1'b1;
      b_if.in_data   = d;
      b_if.delay_sel = 3'd5;
      @(posedge clk);
      #1;
      checks++; if (b_if.out_data !== e) begin errors++; $display("FAIL lanes data[%0d]: got %h want %h", k, b_if.out_data, e); end
      checks++; if (b_if.out_primed !== (k >= 4)) begin errors++; $display("FAIL lanes primed[%0d]: got %b want %b", k, b_if.out_primed, (k >= 4)); end
    end
    b_if.in_valid = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    a_if.in_valid  = 1'b0;
    a_if.in_data   = '0;
    a_if.delay_sel = '0;
    b_if.in_valid  = 1'b0;
    b_if.in_data   = '0;
    b_if.delay_sel = '0;
    test_reset();
    test_const_delay4();
    test_sel_limits();
    test_gaps();
    test_delay_change();
    test_reset_midstream();
    test_multilane();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
